pokey_kb_scan: RTL and testbench
================================

// Module: pokey_kb_scan
// PURPOSE
// - POKEY keypad scan controller: steps a 4-bit scan address over the keypad, samples kr1_n/kr2_n.
// - Debounces a key over two full scans, then latches its keycode and raises a one-cycle keyboard IRQ request.
// - keycode_latch feeds the KBCODE bit-remap block; key_down/shift_down feed SKSTAT; kb_irq_req feeds IRQST logic.
// PARAMETERS
// - SCAN_BITS  4    scan address width (16 keypad positions)
// - SCAN_DIV   114  clk cycles per scan step (one per scan line); must be >= 4
// PORTS
// - clk            in   1          system clock (phi2 domain), all logic on rising edge
// - rst_n          in   1          asynchronous active-low reset
// - scan_en        in   1          SKCTL bit1: keyboard scan enable
// - debounce_en    in   1          SKCTL bit0: two-scan debounce enable
// - kr1_n          in   1          keyboard return, low = key at current k_scan pressed (async)
// - kr2_n          in   1          second return (top button / shift), low = pressed (async)
// - k_scan         out  SCAN_BITS  scan address driven to keypad
// - keycode_latch  out  SCAN_BITS  latched address of last confirmed key
// - key_down       out  1          confirmed key currently held
// - shift_down     out  1          synchronised, inverted kr2_n
// - kb_irq_req     out  1          one-cycle pulse on each new confirmed key
// BEHAVIOUR
// - Reset: all outputs 0, divider 0, FSM IDLE, compare register 0.
// - kr1_n, kr2_n: 2-flop synchronisers each; shift_down = ~kr2_sync; 2-cycle latency.
// - Divider: counts 0..SCAN_DIV-1, wraps to 0.
// - tick: asserted when divider = SCAN_DIV-1.
// - On tick: sample kr1_sync as hit (=~kr1_sync) for the address on k_scan; k_scan then increments (15 -> 0 wrap).
// - The FSM evaluates hit against the current k_scan (pre-increment); match = (k_scan == cmp).
// - FSM states: IDLE, SEEN, HELD, RELEASE. Transitions happen only on tick.
//   - IDLE: hit & debounce_en -> cmp<=k_scan, SEEN.
//   - IDLE: hit & !debounce_en -> latch, HELD.
//   - SEEN: match & hit -> latch, HELD. match & !hit -> IDLE. Non-match: stay.
//   - HELD: match & !hit -> RELEASE if debounce_en, else IDLE. Otherwise stay.
//   - RELEASE: match & hit -> HELD, with no new IRQ and no relatch. match & !hit -> IDLE.
// - latch action: keycode_latch<=k_scan, cmp<=k_scan, key_down<=1, kb_irq_req<=1 for exactly the next cycle.
// - key_down = 1 in HELD and RELEASE, 0 in IDLE and SEEN; registered, updated in the cycle after tick.
// - Multiple keys: hits at non-match addresses while SEEN/HELD/RELEASE are ignored; no rollover, no IRQ.
// - scan_en=0 (level):
//   - divider, k_scan and FSM forced to 0/IDLE and key_down forced to 0 on the next edge.
//   - keycode_latch holds its value; kb_irq_req forced 0; shift_down unaffected.
// - scan_en rising: scan restarts at address 0 with divider 0.
// - debounce_en change mid-scan takes effect at the next tick. No abort of SEEN: SEEN still needs its confirming match.
// - Async reset mid-scan: immediate return to reset values; no IRQ pulse is emitted on release of reset.
// - A full scan takes 16*SCAN_DIV cycles; the debounced new-key IRQ comes one scan after first detection.
// STRUCTURE
// - Shared package pokey_pkg:
//   - kb_state_t enum {KB_IDLE, KB_SEEN, KB_HELD, KB_RELEASE}
//   - KB_SCAN_DIV_DEFAULT = 114
//   - KB_SCAN_BITS = 4
// - One sub-module: pokey_sync2 (2-flop synchroniser), instanced twice.
// - Divider, scan counter and FSM stay in this module.
// TESTING
// - SCAN_DIV=4, debounce_en=1:
//   - Stimulus: hold kr1_n low only while k_scan=5 for two scans.
//   - Required: keycode_latch=5, key_down=1, one kb_irq_req pulse at the second scan's addr-5 tick+1.
// - Same key held for 5 scans, then released:
//   - Required: no further IRQ while held.
//   - Required: key_down drops after two consecutive misses at addr 5; IDLE.
// - debounce_en=0, 1-scan press at addr 0xC:
//   - Required: latch 0xC and IRQ on first detection.
//   - Required: key_down=0 after the first miss at 0xC.
// - Bounce: press at addr 3 in scan 1, absent in scan 2:
//   - Required: no IRQ, key_down stays 0, FSM back to IDLE.
// - Keys 2 and 9 both held, 2 first detected:
//   - Required: keycode_latch=2, single IRQ, hits at 9 ignored.
// - scan_en dropped in HELD:
//   - Required: k_scan=0, key_down=0 next cycle, keycode_latch retained.
// - Async rst_n pulse while SEEN:
//   - Required: all outputs 0 immediately, no IRQ after release.

Source files
------------

// File: rtl/pokey_pkg.sv
// Shared POKEY definitions: keyboard scan FSM states and scan defaults.
package pokey_pkg;

  typedef enum logic [1:0] {
    KB_IDLE    = 2'd0,
    KB_SEEN    = 2'd1,
    KB_HELD    = 2'd2,
    KB_RELEASE = 2'd3
  } kb_state_t;

  localparam int KB_SCAN_DIV_DEFAULT = 114;
  localparam int KB_SCAN_BITS        = 4;

endpackage

// File: rtl/pokey_sync2.sv
// Two-flop synchroniser for an asynchronous level input.
module pokey_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Shift the async input through two flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pokey_kb_scan.sv
// POKEY keypad scanner: steps the scan address, debounces a key over two
// scans, latches its code and pulses an IRQ request for each new key.
module pokey_kb_scan
  import pokey_pkg::*;
#(
  parameter int SCAN_BITS = KB_SCAN_BITS,
  parameter int SCAN_DIV  = KB_SCAN_DIV_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 scan_en,
  input  logic                 debounce_en,
  input  logic                 kr1_n,
  input  logic                 kr2_n,
  output logic [SCAN_BITS-1:0] k_scan,
  output logic [SCAN_BITS-1:0] keycode_latch,
  output logic                 key_down,
  output logic                 shift_down,
  output logic                 kb_irq_req
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic                 kr1_sync, kr2_sync;
  logic [DIV_W-1:0]     div_q;
  logic [SCAN_BITS-1:0] k_scan_q, cmp_q, code_q;
  kb_state_t            state_q, state_d;
  logic                 key_down_q, irq_q;
  logic                 tick, hit, match, do_latch, do_cmp;

  // Synchronisers idle high so released keys read as "not pressed" at reset.
  pokey_sync2 #(.RST_VAL(1'b1)) u_sync_kr1 (
    .clk(clk), .rst_n(rst_n), .d_i(kr1_n), .q_o(kr1_sync)
  );
  pokey_sync2 #(.RST_VAL(1'b1)) u_sync_kr2 (
    .clk(clk), .rst_n(rst_n), .d_i(kr2_n), .q_o(kr2_sync)
  );

  assign tick  = scan_en && (div_q == DIV_LAST);
  assign hit   = ~kr1_sync;
  assign match = (k_scan_q == cmp_q);

  // Next-state and latch decisions, evaluated against the pre-increment address.
  always_comb begin
    state_d  = state_q;
    do_latch = 1'b0;
    do_cmp   = 1'b0;
    if (tick) begin
      unique case (state_q)
        KB_IDLE: begin
          if (hit) begin
            if (debounce_en) begin
              do_cmp  = 1'b1;
              state_d = KB_SEEN;
            end else begin
              do_latch = 1'b1;
              state_d  = KB_HELD;
            end
          end
        end
        KB_SEEN: begin
          if (match) begin
            if (hit) begin
              do_latch = 1'b1;
              state_d  = KB_HELD;
            end else begin
              state_d = KB_IDLE;
            end
          end
        end
        KB_HELD: begin
          if (match && !hit) state_d = debounce_en ? KB_RELEASE : KB_IDLE;
        end
        KB_RELEASE: begin
          if (match) state_d = hit ? KB_HELD : KB_IDLE;
        end
        default: state_d = KB_IDLE;
      endcase
    end
  end

  // Divider, scan address, FSM and output registers; scan_en low parks the scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= '0;
      k_scan_q   <= '0;
      state_q    <= KB_IDLE;
      cmp_q      <= '0;
      code_q     <= '0;
      key_down_q <= 1'b0;
      irq_q      <= 1'b0;
    end else if (!scan_en) begin
      div_q      <= '0;
      k_scan_q   <= '0;
      state_q    <= KB_IDLE;
      key_down_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      div_q      <= tick ? '0 : div_q + 1'b1;
      if (tick) k_scan_q <= k_scan_q + 1'b1;
      state_q    <= state_d;
      if (do_latch || do_cmp) cmp_q <= k_scan_q;
      if (do_latch) code_q <= k_scan_q;
      irq_q      <= do_latch;
      key_down_q <= (state_d == KB_HELD) || (state_d == KB_RELEASE);
    end
  end

  assign k_scan        = k_scan_q;
  assign keycode_latch = code_q;
  assign key_down      = key_down_q;
  assign shift_down    = ~kr2_sync;
  assign kb_irq_req    = irq_q;

endmodule

// File: tb/tb_pokey_kb_scan.sv
// Self-checking bench for pokey_kb_scan with a keypad model and IRQ scoreboard.
module tb_pokey_kb_scan;

  logic       clk = 1'b0;
  logic       rst_n, scan_en, debounce_en, kr2_n;
  logic       kr1_n;
  logic [3:0] k_scan, keycode_latch;
  logic       key_down, shift_down, kb_irq_req;
  logic [15:0] keys;        // keypad model: bit set = key held
  logic [3:0]  exp_q[$];    // expected keycodes of future IRQs
  int nchk = 0, nerr = 0;
  logic prev_irq = 1'b0;

  always #5 clk = ~clk;

  assign kr1_n = ~keys[k_scan];

  pokey_kb_scan #(.SCAN_BITS(4), .SCAN_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .debounce_en(debounce_en),
    .kr1_n(kr1_n), .kr2_n(kr2_n), .k_scan(k_scan), .keycode_latch(keycode_latch),
    .key_down(key_down), .shift_down(shift_down), .kb_irq_req(kb_irq_req)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard: every IRQ pulse must match the next expected keycode and last one cycle.
  always @(negedge clk) begin
    if (rst_n && kb_irq_req) begin
      check("irq_width", prev_irq, 1'b0);
      if (exp_q.size() == 0) check("irq_unexpected", 1, 0);
      else begin
        check("irq_code", keycode_latch, exp_q.pop_front());
        check("irq_keydown", key_down, 1'b1);
      end
    end
    prev_irq <= kb_irq_req;
  end

  // Wait until the tick at address a has been taken (k_scan moves off a).
  task automatic pass_addr(input logic [3:0] a);
    int n;
    n = 0;
    while (k_scan !== a && n < 200) begin @(negedge clk); n++; end
    while (k_scan === a && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) check($sformatf("timeout_addr%0d", a), 0, 1);
  endtask

  initial begin
    rst_n = 1'b0; scan_en = 1'b1; debounce_en = 1'b1; kr2_n = 1'b1; keys = '0;
    repeat (3) @(negedge clk);
    check("rst_kscan", k_scan, 0);
    check("rst_code", keycode_latch, 0);
    check("rst_keydown", key_down, 0);
    check("rst_shift", shift_down, 0);
    check("rst_irq", kb_irq_req, 0);
    rst_n = 1'b1;

    // Debounced press at 5, held for five scans, then released.
    keys[5] = 1'b1;
    pass_addr(5);
    check("seen_keydown", key_down, 0);
    exp_q.push_back(4'd5);
    pass_addr(5);
    check("held_keydown", key_down, 1);
    check("held_code", keycode_latch, 5);
    repeat (3) pass_addr(5);
    check("held5_keydown", key_down, 1);
    keys = '0;
    pass_addr(5);
    check("miss1_keydown", key_down, 1);
    pass_addr(5);
    check("miss2_keydown", key_down, 0);
    check("miss2_code", keycode_latch, 5);

    // No debounce: immediate latch at 0xC, drop on first miss.
    debounce_en = 1'b0;
    keys[12] = 1'b1;
    exp_q.push_back(4'hC);
    pass_addr(12);
    check("nodb_keydown", key_down, 1);
    check("nodb_code", keycode_latch, 4'hC);
    keys = '0;
    pass_addr(12);
    check("nodb_release", key_down, 0);

    // Bounce at 3: seen once, then absent.
    debounce_en = 1'b1;
    keys[3] = 1'b1;
    pass_addr(3);
    keys = '0;
    pass_addr(3);
    check("bounce_keydown", key_down, 0);
    pass_addr(3);
    check("bounce_idle_keydown", key_down, 0);
    check("bounce_code", keycode_latch, 4'hC);

    // Two keys, 2 seen first; 9 ignored.
    pass_addr(9);
    keys[2] = 1'b1; keys[9] = 1'b1;
    pass_addr(2);
    exp_q.push_back(4'd2);
    pass_addr(2);
    check("two_code", keycode_latch, 2);
    pass_addr(9);
    check("two_code9", keycode_latch, 2);
    check("two_keydown", key_down, 1);

    // scan_en dropped while HELD.
    pass_addr(6);
    scan_en = 1'b0;
    @(negedge clk);
    check("scanoff_kscan", k_scan, 0);
    check("scanoff_keydown", key_down, 0);
    check("scanoff_code", keycode_latch, 2);
    keys = '0;
    scan_en = 1'b1;
    @(negedge clk);
    check("scanon_kscan", k_scan, 0);

    // Async reset while SEEN.
    keys[1] = 1'b1;
    pass_addr(1);
    keys = '0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_code", keycode_latch, 0);
    check("arst_kscan", k_scan, 0);
    check("arst_keydown", key_down, 0);
    check("arst_irq", kb_irq_req, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pass_addr(1);
    pass_addr(1);
    check("arst_after_keydown", key_down, 0);

    // Shift synchroniser latency.
    kr2_n = 1'b0;
    @(negedge clk);
    check("shift_lat1", shift_down, 0);
    @(negedge clk);
    check("shift_lat2", shift_down, 1);

    check("irq_pending", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
